// File: rtl/ps2_kb_port.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kb_port
// Brief    : PS/2 set-2 keyboard receiver with E0/F0 prefix folding and a
//            key-event FIFO popped by the CPU read strobe.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kb_port #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       kb_rd,
    output logic [9:0] ps2kb_key,
    output logic       kb_ready,
    output logic       kb_overflow,
    output logic       kb_err
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_clk_sync;
    logic [1:0]        r_dat_sync;
    logic [2:0]        r_bit_cnt;
    logic [c_TW-1:0]   r_timer;
    logic [7:0]        r_shift;
    logic              r_par;
    logic              r_ext;
    logic              r_brk;
    logic              r_err;
    logic              r_rd_q;
    logic              r_ovf;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [9:0]        r_mem [FIFO_DEPTH];

    logic w_fall, w_data, w_timeout, w_err, w_byte_ok, w_frame_bad;
    logic w_is_e0, w_is_f0, w_push, w_empty, w_full, w_pop, w_wr;

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_data    = r_dat_sync[1];
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_timer == c_TW'(TIMEOUT_CYC));

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_byte_ok   = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            S_IDLE: if (w_fall) begin
                if (!w_data) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_err       = 1'b1;
                    w_frame_bad = 1'b1;
                end
            end
            S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_fall) w_state_nxt = S_STOP;
            S_STOP: if (w_fall) begin
                w_state_nxt = S_IDLE;
                if (w_data && ((^r_shift) ^ r_par)) begin
                    w_byte_ok = 1'b1;
                end else begin
                    w_err       = 1'b1;
                    w_frame_bad = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Timeout aborts the frame but leaves prefix flags intact
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
        end
    end

    assign w_is_e0 = (r_shift == 8'hE0);
    assign w_is_f0 = (r_shift == 8'hF0);
    assign w_push  = w_byte_ok && !w_is_e0 && !w_is_f0;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (c_AW+1)'(FIFO_DEPTH));
    assign w_pop   = kb_rd & ~r_rd_q & ~w_empty;
    // A simultaneous pop frees the slot for a push into a full FIFO
    assign w_wr    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_timer    <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_err      <= 1'b0;
            r_rd_q     <= 1'b0;
            r_ovf      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_state    <= w_state_nxt;
            r_err      <= w_err;
            r_rd_q     <= kb_rd;

            if (r_state == S_IDLE || w_fall || w_timeout) r_timer <= '0;
            else                                          r_timer <= r_timer + 1'b1;

            if (r_state == S_IDLE && w_fall) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA && w_fall) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == S_PARITY && w_fall) r_par <= w_data;

            if (w_frame_bad || w_push) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_ok && w_is_e0) begin
                r_ext <= 1'b1;
            end else if (w_byte_ok && w_is_f0) begin
                r_brk <= 1'b1;
            end

            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_AW+1)'(w_wr) - (c_AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_brk, r_ext, r_shift};
    end

    assign ps2kb_key   = w_empty ? 10'h000 : r_mem[r_rd_ptr];
    assign kb_ready    = ~w_empty;
    assign kb_overflow = r_ovf;
    assign kb_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kb_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kb_port
// Brief    : Randomized scoreboard bench for ps2_kb_port against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kb_port;

    localparam int c_DEPTH = 8;
    localparam int c_TO    = 200;
    localparam int c_H     = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kb_rd = 1'b0;
    logic [9:0] ps2kb_key;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_err;

    ps2_kb_port #(.FIFO_DEPTH(c_DEPTH), .TIMEOUT_CYC(c_TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kb_rd       (kb_rd),
        .ps2kb_key   (ps2kb_key),
        .kb_ready    (kb_ready),
        .kb_overflow (kb_overflow),
        .kb_err      (kb_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [9:0] exp_q [$];
    bit         m_ext = 0, m_brk = 0, m_ovf = 0;
    int         m_err = 0;
    int         err_seen = 0;
    bit         rd_prev = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every CPU read rising edge pops the model and compares the head
    always @(negedge clk) begin
        if (!rst) begin
            rd_prev = kb_rd;
        end else begin
            if (kb_err) err_seen++;
            if (kb_rd && !rd_prev) begin
                if (exp_q.size() > 0) begin
                    check("rd_key", 32'(ps2kb_key), 32'(exp_q[0]));
                    check("rd_ready", 32'(kb_ready), 32'd1);
                    void'(exp_q.pop_front());
                end else begin
                    check("rd_empty_key", 32'(ps2kb_key), 32'h0);
                    check("rd_empty_ready", 32'(kb_ready), 32'd0);
                end
            end
            rd_prev = kb_rd;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(c_H);
            ps2_clk = 1'b0;
            wait_clk(c_H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic model_push(input logic [9:0] ev);
        if (exp_q.size() < c_DEPTH) exp_q.push_back(ev);
        else                        m_ovf = 1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    task automatic frame(input logic [7:0] b, input int kind);
        logic par, stp;
        par = ~(^b);
        stp = 1'b1;
        if (kind == 1) par = ~par;
        if (kind == 2) stp = 1'b0;
        if (kind == 3) send_bits(11'h001, 1);
        else           send_bits({stp, par, b, 1'b0}, 11);
        wait_clk(30);
        if (kind != 0) begin
            m_err++;
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            model_push({m_brk, m_ext, b});
            m_ext = 0;
            m_brk = 0;
        end
        check("frm_ready", 32'(kb_ready), 32'(exp_q.size() != 0));
        check("frm_key", 32'(ps2kb_key), exp_q.size() != 0 ? 32'(exp_q[0]) : 32'h0);
        check("frm_err", 32'(err_seen), 32'(m_err));
        check("frm_ovf", 32'(kb_overflow), 32'(m_ovf));
    endtask

    task automatic do_read(input int hold);
        kb_rd = 1'b1;
        wait_clk(hold);
        kb_rd = 1'b0;
        wait_clk(2);
        check("post_rd_key", 32'(ps2kb_key), exp_q.size() != 0 ? 32'(exp_q[0]) : 32'h0);
        check("post_rd_ready", 32'(kb_ready), 32'(exp_q.size() != 0));
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) do_read(1);
    endtask

    initial begin
        logic [7:0] b;
        int r;
        #1;
        check("rst_key", 32'(ps2kb_key), 32'h0);
        check("rst_ready", 32'(kb_ready), 32'd0);
        check("rst_ovf", 32'(kb_overflow), 32'd0);
        check("rst_err", 32'(kb_err), 32'd0);
        wait_clk(4);
        rst = 1'b1;
        wait_clk(4);

        frame(8'h1C, 0);
        check("key_01c", 32'(ps2kb_key), 32'h01C);
        do_read(3);
        check("held_pop", 32'(kb_ready), 32'd0);

        frame(8'hE0, 0); frame(8'hF0, 0); frame(8'h75, 0);
        check("key_375", 32'(ps2kb_key), 32'h375);
        frame(8'hF0, 0); frame(8'h1C, 0);
        do_read(2);
        check("key_21c", 32'(ps2kb_key), 32'h21C);
        drain();

        frame(8'h1C, 1);
        check("par_empty", 32'(kb_ready), 32'd0);
        frame(8'hE0, 0); frame(8'h33, 2); frame(8'h1C, 0);
        check("ext_cleared", 32'(ps2kb_key), 32'h01C);
        drain();
        frame(8'hF0, 0); frame(8'h00, 3); frame(8'h1C, 0);
        check("brk_cleared", 32'(ps2kb_key), 32'h01C);
        drain();

        for (int i = 1; i <= 9; i++) frame(8'(i), 0);
        check("ovf_set", 32'(kb_overflow), 32'd1);
        for (int i = 0; i < 9; i++) do_read(1);

        send_bits({1'b1, 1'b0, 8'h2A, 1'b0}, 5);
        wait_clk(c_TO + 5);
        wait_clk(10);
        m_err++;
        check("timeout_err", 32'(err_seen), 32'(m_err));
        frame(8'h2A, 0);
        check("key_02a", 32'(ps2kb_key), 32'h02A);
        drain();

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 99);
            if      (r < 12) frame(8'hE0, 0);
            else if (r < 24) frame(8'hF0, 0);
            else if (r < 66) begin
                do b = 8'($urandom); while (b == 8'hE0 || b == 8'hF0);
                frame(b, 0);
            end
            else if (r < 71) frame(8'($urandom), 1);
            else if (r < 75) frame(8'($urandom), 2);
            else if (r < 78) frame(8'h00, 3);
            else             do_read($urandom_range(1, 4));
        end
        drain();

        frame(8'h11, 0); frame(8'h22, 0); frame(8'h33, 0);
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4);
        ps2_clk = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        #1;
        check("mid_rst_key", 32'(ps2kb_key), 32'h0);
        check("mid_rst_ready", 32'(kb_ready), 32'd0);
        check("mid_rst_ovf", 32'(kb_overflow), 32'd0);
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(5);
        frame(8'h1C, 0);
        check("after_rst_key", 32'(ps2kb_key), 32'h01C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
